// File: rtl/btn_event_array.sv
// btn_event_array
//   N_CH independent push-button front ends sharing one 1 ms tick prescaler
//   and one post-reset event mask. Each channel has a 2-flop synchroniser,
//   polarity normalisation, tick-based debounce, press/release pulses,
//   long-press detection and auto-repeat.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   btn         raw asynchronous button pins
//   ready       high once the startup mask has expired
//   pressed     debounced level per channel, 1 = pressed
//   press       1-cycle pulse when a press is accepted
//   rel         1-cycle pulse when a release is accepted
//   long_press  1-cycle pulse once per hold, LONG_MS ticks after press
//   rpt         1-cycle pulse every REPEAT_MS ticks after long_press

module btn_event_array #(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned CLK_HZ      = 27_000_000,
    parameter int unsigned STARTUP_MS  = 10,
    parameter int unsigned DEBOUNCE_MS = 5,
    parameter int unsigned LONG_MS     = 800,
    parameter int unsigned REPEAT_MS   = 150,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn,
    output logic            ready,
    output logic [N_CH-1:0] pressed,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] rel,
    output logic [N_CH-1:0] long_press,
    output logic [N_CH-1:0] rpt
);

    localparam int unsigned TICK_DIV = CLK_HZ / 1000;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = $clog2(STARTUP_MS + 1);
    localparam int unsigned DW = $clog2(DEBOUNCE_MS + 1);
    localparam int unsigned HW = $clog2(LONG_MS + 1);
    localparam int unsigned RW = (REPEAT_MS > 0) ? $clog2(REPEAT_MS + 1) : 1;

    localparam logic [PW-1:0] PRESC_LAST   = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STARTUP_LAST = SW'(STARTUP_MS - 1);
    localparam logic [DW-1:0] DB_LAST      = DW'(DEBOUNCE_MS - 1);
    localparam logic [HW-1:0] HOLD_MAX     = HW'(LONG_MS);
    localparam logic [HW-1:0] HOLD_LAST    = HW'(LONG_MS - 1);
    localparam logic [RW-1:0] REP_LAST     = RW'((REPEAT_MS > 0) ? REPEAT_MS - 1 : 0);
    localparam logic          RELEASED_PIN = ACTIVE_LOW;

    // ------------------------------------------------------------------
    // Shared 1 ms tick. With TICK_DIV = 1 the prescaler sits at 0 and the
    // tick is high every cycle.
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q;
    logic          tick;

    assign tick = (presc_q == PRESC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Startup mask: ready rises on the tick that brings the count to
    // STARTUP_MS and then sticks until reset.
    // ------------------------------------------------------------------
    logic [SW-1:0] st_cnt_q;
    logic          ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_cnt_q <= '0;
            ready_q  <= 1'b0;
        end else if (!ready_q && tick) begin
            st_cnt_q <= st_cnt_q + SW'(1);
            if (st_cnt_q == STARTUP_LAST) begin
                ready_q <= 1'b1;
            end
        end
    end

    assign ready = ready_q;

    // ------------------------------------------------------------------
    // Synchroniser, reset to the released pin level, then normalised so
    // that s = 1 means pressed.
    // ------------------------------------------------------------------
    logic [N_CH-1:0] sync1_q, sync2_q;
    logic [N_CH-1:0] s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= {N_CH{RELEASED_PIN}};
            sync2_q <= {N_CH{RELEASED_PIN}};
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q ^ {N_CH{ACTIVE_LOW}};

    // ------------------------------------------------------------------
    // Per-channel debounce, hold timing and repeat.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
        logic          stable_q, stable_d;
        logic [DW-1:0] db_q, db_d;
        logic [HW-1:0] hold_q, hold_d;
        logic [RW-1:0] rep_q, rep_d;
        // armed: the current hold began with a press pulse (not inherited
        // from the startup mask); rep_on: long_press has fired this hold.
        logic          armed_q, armed_d;
        logic          rep_on_q, rep_on_d;
        logic          press_q, press_d;
        logic          rel_q, rel_d;
        logic          long_q, long_d;
        logic          rpt_q, rpt_d;
        logic          flip;

        assign flip = (s[i] != stable_q) && (db_q == DB_LAST);

        always_comb begin
            stable_d = stable_q;
            db_d     = db_q;
            hold_d   = hold_q;
            rep_d    = rep_q;
            armed_d  = armed_q;
            rep_on_d = rep_on_q;
            press_d  = 1'b0;
            rel_d    = 1'b0;
            long_d   = 1'b0;
            rpt_d    = 1'b0;

            if (!ready_q) begin
                // Masked: track the pin silently so no event is seen later.
                stable_d = s[i];
                db_d     = '0;
                hold_d   = '0;
                rep_d    = '0;
                armed_d  = 1'b0;
                rep_on_d = 1'b0;
            end else if (tick) begin
                if (flip) begin
                    // Accepted level change wins over hold/repeat this cycle.
                    stable_d = s[i];
                    db_d     = '0;
                    hold_d   = '0;
                    rep_d    = '0;
                    rep_on_d = 1'b0;
                    armed_d  = s[i];
                    press_d  = s[i];
                    rel_d    = !s[i];
                end else begin
                    db_d = (s[i] == stable_q) ? '0 : db_q + DW'(1);
                    if (stable_q) begin
                        if (rep_on_q) begin
                            if (rep_q == REP_LAST) begin
                                rep_d = '0;
                                rpt_d = 1'b1;
                            end else begin
                                rep_d = rep_q + RW'(1);
                            end
                        end
                        if (hold_q != HOLD_MAX) begin
                            hold_d = hold_q + HW'(1);
                        end
                        if ((hold_q == HOLD_LAST) && armed_q) begin
                            long_d   = 1'b1;
                            rep_on_d = (REPEAT_MS != 0);
                            rep_d    = '0;
                        end
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stable_q <= 1'b0;
                db_q     <= '0;
                hold_q   <= '0;
                rep_q    <= '0;
                armed_q  <= 1'b0;
                rep_on_q <= 1'b0;
                press_q  <= 1'b0;
                rel_q    <= 1'b0;
                long_q   <= 1'b0;
                rpt_q    <= 1'b0;
            end else begin
                stable_q <= stable_d;
                db_q     <= db_d;
                hold_q   <= hold_d;
                rep_q    <= rep_d;
                armed_q  <= armed_d;
                rep_on_q <= rep_on_d;
                press_q  <= press_d;
                rel_q    <= rel_d;
                long_q   <= long_d;
                rpt_q    <= rpt_d;
            end
        end

        assign pressed[i]    = stable_q;
        assign press[i]      = press_q;
        assign rel[i]        = rel_q;
        assign long_press[i] = long_q;
        assign rpt[i]        = rpt_q;
    end

endmodule

// File: tb/tb_btn_event_array.sv
// Bench for btn_event_array with a 1-cycle tick (CLK_HZ = 1000).
// The reference model works from edge timestamps: the debounced level flips
// when the last DEBOUNCE_MS synchronised samples all disagree with it, and
// long/repeat pulses are derived from the age of the hold since its press.

module tb_btn_event_array;

    localparam int N_CH        = 3;
    localparam int CLK_HZ      = 1000;
    localparam int STARTUP_MS  = 4;
    localparam int DEBOUNCE_MS = 3;
    localparam int LONG_MS     = 10;
    localparam int REPEAT_MS   = 4;
    localparam bit ACTIVE_LOW  = 1'b1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_CH-1:0] btn = '1;
    logic            ready;
    logic [N_CH-1:0] pressed, press, rel, long_press, rpt;

    always #5 clk = ~clk;

    btn_event_array #(
        .N_CH        (N_CH),
        .CLK_HZ      (CLK_HZ),
        .STARTUP_MS  (STARTUP_MS),
        .DEBOUNCE_MS (DEBOUNCE_MS),
        .LONG_MS     (LONG_MS),
        .REPEAT_MS   (REPEAT_MS),
        .ACTIVE_LOW  (ACTIVE_LOW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (btn),
        .ready      (ready),
        .pressed    (pressed),
        .press      (press),
        .rel        (rel),
        .long_press (long_press),
        .rpt        (rpt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state. hist[k] is the pin vector present at edge k+1.
    logic [N_CH-1:0] hist[$];
    int              m_cyc;
    logic [N_CH-1:0] m_stable;
    int              m_tpress[N_CH];
    logic            m_ready;
    logic [N_CH-1:0] e_press, e_rel, e_long, e_rpt;

    // Observed event tallies for scenario-level checks.
    int cnt_press[N_CH];
    int cnt_rel[N_CH];
    int cnt_long[N_CH];
    int cnt_rpt[N_CH];
    int last_press_cyc[N_CH];
    int updown;

    task automatic check(input string tag, input logic [N_CH-1:0] obs,
                         input logic [N_CH-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // Pressed level seen by the debouncer at edge n: the pin two edges earlier.
    function automatic logic s_at(input int n, input int ch);
        if (n < 3) return 1'b0;
        return hist[n-3][ch] ^ ACTIVE_LOW;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_cyc    = 0;
        m_stable = '0;
        m_ready  = 1'b0;
        for (int c = 0; c < N_CH; c++) m_tpress[c] = -1;
    endtask

    task automatic model_edge();
        logic sv;
        bit   flip;
        int   age;
        m_cyc++;
        e_press = '0;
        e_rel   = '0;
        e_long  = '0;
        e_rpt   = '0;
        for (int c = 0; c < N_CH; c++) begin
            sv = s_at(m_cyc, c);
            if (m_cyc <= STARTUP_MS) begin
                m_stable[c] = sv;
                m_tpress[c] = -1;
            end else begin
                flip = 1'b1;
                for (int k = 0; k < DEBOUNCE_MS; k++) begin
                    if ((m_cyc - k) <= STARTUP_MS || s_at(m_cyc - k, c) == m_stable[c])
                        flip = 1'b0;
                end
                if (flip) begin
                    m_stable[c] = ~m_stable[c];
                    if (m_stable[c]) begin
                        e_press[c]  = 1'b1;
                        m_tpress[c] = m_cyc;
                    end else begin
                        e_rel[c]    = 1'b1;
                        m_tpress[c] = -1;
                    end
                end else if (m_stable[c] && m_tpress[c] >= 0) begin
                    age = m_cyc - m_tpress[c];
                    if (age == LONG_MS) e_long[c] = 1'b1;
                    else if (REPEAT_MS > 0 && age > LONG_MS && (age - LONG_MS) % REPEAT_MS == 0)
                        e_rpt[c] = 1'b1;
                end
            end
        end
        m_ready = (m_cyc >= STARTUP_MS);
    endtask

    task automatic clear_counts();
        for (int c = 0; c < N_CH; c++) begin
            cnt_press[c] = 0;
            cnt_rel[c]   = 0;
            cnt_long[c]  = 0;
            cnt_rpt[c]   = 0;
        end
    endtask

    // One clock: drive pins at the falling edge, compare #1 after the rising edge.
    task automatic step(input logic [N_CH-1:0] b);
        btn = b;
        hist.push_back(b);
        @(posedge clk);
        #1;
        model_edge();
        check("ready", N_CH'(ready), N_CH'(m_ready));
        check("pressed", pressed, m_stable);
        check("press", press, e_press);
        check("rel", rel, e_rel);
        check("long_press", long_press, e_long);
        check("rpt", rpt, e_rpt);
        for (int c = 0; c < N_CH; c++) begin
            cnt_press[c] += int'(press[c]);
            cnt_rel[c]   += int'(rel[c]);
            cnt_long[c]  += int'(long_press[c]);
            cnt_rpt[c]   += int'(rpt[c]);
            if (press[c]) last_press_cyc[c] = m_cyc;
        end
        updown += int'(press[0]) - int'(press[1]);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, N_CH'(ready), '0);
        check({tag, "_pressed"}, pressed, '0);
        check({tag, "_press"}, press, '0);
        check({tag, "_rel"}, rel, '0);
        check({tag, "_long"}, long_press, '0);
        check({tag, "_rpt"}, rpt, '0);
    endtask

    initial begin
        int              run[N_CH];
        logic [N_CH-1:0] lvl;
        int              ud0;

        updown = 0;
        for (int c = 0; c < N_CH; c++) last_press_cyc[c] = -1;
        model_reset();
        clear_counts();

        // Button 0 already held while in reset.
        btn = 3'b110;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Held through the mask: level shows, no press, release accepted.
        for (int i = 0; i < 30; i++) step(3'b110);
        for (int i = 0; i < 10; i++) step(3'b111);
        check_int("sc1_press0", cnt_press[0], 0);
        check_int("sc1_rel0", cnt_rel[0], 1);

        // Clean short press on channel 1.
        clear_counts();
        for (int i = 0; i < 8; i++) step(3'b101);
        for (int i = 0; i < 10; i++) step(3'b111);
        check_int("sc2_press1", cnt_press[1], 1);
        check_int("sc2_rel1", cnt_rel[1], 1);
        check_int("sc2_long1", cnt_long[1], 0);

        // Glitches on channel 2 shorter than the debounce window.
        clear_counts();
        repeat (2) step(3'b011);
        step(3'b111);
        repeat (2) step(3'b011);
        repeat (6) step(3'b111);
        check_int("sc3_glitch_press2", cnt_press[2], 0);
        repeat (6) step(3'b011);
        repeat (8) step(3'b111);
        check_int("sc3_steady_press2", cnt_press[2], 1);

        // Long hold; release is accepted on the edge a third rpt would be due.
        clear_counts();
        for (int i = 0; i < 22; i++) step(3'b110);
        for (int i = 0; i < 8; i++) step(3'b111);
        check_int("sc4_press0", cnt_press[0], 1);
        check_int("sc4_long0", cnt_long[0], 1);
        check_int("sc4_rpt0", cnt_rpt[0], 2);
        check_int("sc4_rel0", cnt_rel[0], 1);

        // Simultaneous presses cancel in an up/down counter.
        clear_counts();
        ud0 = updown;
        for (int i = 0; i < 6; i++) step(3'b100);
        for (int i = 0; i < 8; i++) step(3'b111);
        check_int("sc5_press0", cnt_press[0], 1);
        check_int("sc5_press1", cnt_press[1], 1);
        check_int("sc5_same_cycle", last_press_cyc[0], last_press_cyc[1]);
        check_int("sc5_updown", updown, ud0);

        // Reset during repeat, with the button still held afterwards.
        clear_counts();
        for (int i = 0; i < 20; i++) step(3'b110);
        check_int("sc6_rpt_before_reset", cnt_rpt[0], 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        model_reset();
        clear_counts();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) step(3'b110);
        check_int("sc6_no_press_after", cnt_press[0], 0);
        check_int("sc6_no_long_after", cnt_long[0], 0);
        for (int i = 0; i < 8; i++) step(3'b111);

        // Random run lengths: mixes glitches, short presses and long holds.
        lvl = '1;
        for (int c = 0; c < N_CH; c++) run[c] = 0;
        for (int t = 0; t < 400; t++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (run[c] == 0) begin
                    lvl[c] = ~lvl[c];
                    run[c] = int'($urandom_range(24, 1));
                end
                run[c]--;
            end
            step(lvl);
        end
        for (int i = 0; i < 10; i++) step(3'b111);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
